// File: rtl/bpu_update_queue_if.sv
// ---------------------------------------------------------------------------
// bpu_update_queue_if
//   Bundles the fetch-side prediction push, the execute-side resolve port and
//   the predictor update/redirect outputs of bpu_update_queue.
//
//   Handshake rules:
//     push    : an entry is accepted on a rising clk edge iff
//               pred_valid_i & pred_ready_o. pred_ready_o is a registered
//               function of occupancy and never depends combinationally on
//               any input.
//     resolve : resolve_valid_i has no ready. It always refers to the oldest
//               in-flight entry and is ignored when the queue is empty.
//     update  : branch_valid_o / mispredict_o are single-cycle pulses. They
//               appear exactly one cycle after the resolve cycle. The data
//               outputs that go with them are valid while branch_valid_o = 1.
//
//   Modports:
//     master : fetch/execute side (drives pred_* / resolve_*)
//     slave  : the queue itself
//
//   Parameter: ADDR_WIDTH -- PC/target width
// ---------------------------------------------------------------------------
interface bpu_update_queue_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  pred_valid_i;
    logic [ADDR_WIDTH-1:0] pred_pc_i;
    logic                  pred_taken_i;
    logic [ADDR_WIDTH-1:0] pred_target_i;
    logic                  pred_ready_o;

    logic                  resolve_valid_i;
    logic                  resolve_taken_i;
    logic [ADDR_WIDTH-1:0] resolve_target_i;

    logic                  branch_valid_o;
    logic                  branch_taken_o;
    logic [ADDR_WIDTH-1:0] branch_pc_o;
    logic [ADDR_WIDTH-1:0] branch_target_address_o;
    logic                  mispredict_o;
    logic [ADDR_WIDTH-1:0] redirect_pc_o;

    modport master (
        output pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
        input  pred_ready_o,
        output resolve_valid_i, resolve_taken_i, resolve_target_i,
        input  branch_valid_o, branch_taken_o, branch_pc_o,
        input  branch_target_address_o, mispredict_o, redirect_pc_o
    );

    modport slave (
        input  pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
        output pred_ready_o,
        input  resolve_valid_i, resolve_taken_i, resolve_target_i,
        output branch_valid_o, branch_taken_o, branch_pc_o,
        output branch_target_address_o, mispredict_o, redirect_pc_o
    );
endinterface

// File: rtl/bpu_update_queue.sv
// ---------------------------------------------------------------------------
// bpu_update_queue
//   In-order queue of branch predictions. Fetch pushes every prediction it
//   makes. Execute resolves branches oldest-first. Each resolution is paired
//   with the recorded prediction and produces one registered update for the
//   predictor/BTB. On a wrong prediction the module raises a redirect and
//   drops every younger (wrong-path) entry.
//
//   Ports:
//     clk               clock; all state changes on posedge
//     rst               asynchronous, active-low reset
//     flush_i           external pipeline flush; empties the queue and
//                       cancels any push/resolve in the same cycle
//     bus (slave)       pred_* push port, resolve_* port, branch_*/
//                       mispredict_o/redirect_pc_o update outputs
//     occupancy_o       number of valid entries (0..DEPTH)
//     perf_resolved_o   resolved-branch count (0 unless BPU_PERF_COUNTER_EN)
//     perf_mispredict_o mispredict count     (0 unless BPU_PERF_COUNTER_EN)
//
//   Optional feature macro: BPU_PERF_COUNTER_EN
//     When defined, this adds saturating 32-bit counters. Only reset clears
//     them. When not defined, both perf ports are tied to zero.
//
//   Parameters: DEPTH (power of 2, >= 2), ADDR_WIDTH (must equal the bus
//   interface's ADDR_WIDTH).
// ---------------------------------------------------------------------------
module bpu_update_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    bpu_update_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [31:0]              perf_resolved_o,
    output logic [31:0]              perf_mispredict_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    // Entry storage
    logic [ADDR_WIDTH-1:0] pc_mem_q     [DEPTH];
    logic [ADDR_WIDTH-1:0] target_mem_q [DEPTH];
    logic                  taken_mem_q  [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   occ_q, occ_d;

    // Registered update outputs
    logic                  branch_valid_q;
    logic                  branch_taken_q;
    logic [ADDR_WIDTH-1:0] branch_pc_q;
    logic [ADDR_WIDTH-1:0] branch_target_q;
    logic                  mispredict_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;

    logic                  push_acc;
    logic                  resolve_acc;
    logic                  mis;
    logic                  resolve_mis;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_target;
    logic                  head_taken;

    assign head_pc     = pc_mem_q[rd_ptr_q];
    assign head_target = target_mem_q[rd_ptr_q];
    assign head_taken  = taken_mem_q[rd_ptr_q];

    // ready comes from the occupancy register only, so fetch sees no
    // combinational path through the resolve inputs.
    assign bus.pred_ready_o = (occ_q != FULL);

    assign push_acc    = bus.pred_valid_i && (occ_q != FULL) && !flush_i;
    assign resolve_acc = bus.resolve_valid_i && (occ_q != '0) && !flush_i;

    // The target only matters when the branch is actually taken. A not-taken
    // branch that was predicted not-taken is a hit, whatever target was recorded.
    assign mis = (head_taken != bus.resolve_taken_i) ||
                 (bus.resolve_taken_i && (head_target != bus.resolve_target_i));
    assign resolve_mis = resolve_acc && mis;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush_i || resolve_mis) begin
            // Everything after the head is wrong-path. A same-cycle push is
            // dropped by leaving wr_ptr alone.
            rd_ptr_d = wr_ptr_q;
            occ_d    = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (resolve_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_acc, resolve_acc})
                2'b10:   occ_d = occ_q + (PW+1)'(1);
                2'b01:   occ_d = occ_q - (PW+1)'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]     <= '0;
                target_mem_q[i] <= '0;
                taken_mem_q[i]  <= 1'b0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            // A push that a mispredict discards still writes its slot. That
            // slot lies outside the valid window, so no one reads it.
            if (push_acc) begin
                pc_mem_q[wr_ptr_q]     <= bus.pred_pc_i;
                target_mem_q[wr_ptr_q] <= bus.pred_target_i;
                taken_mem_q[wr_ptr_q]  <= bus.pred_taken_i;
            end
        end
    end

    // Update outputs: strobes pulse, data holds the last resolution.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_valid_q  <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_pc_q     <= '0;
            branch_target_q <= '0;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
        end else begin
            branch_valid_q <= resolve_acc;
            mispredict_q   <= resolve_mis;
            if (resolve_acc) begin
                branch_taken_q  <= bus.resolve_taken_i;
                branch_pc_q     <= head_pc;
                branch_target_q <= bus.resolve_target_i;
                redirect_pc_q   <= bus.resolve_taken_i ? bus.resolve_target_i
                                                       : head_pc + ADDR_WIDTH'(4);
            end
        end
    end

    assign bus.branch_valid_o          = branch_valid_q;
    assign bus.branch_taken_o          = branch_taken_q;
    assign bus.branch_pc_o             = branch_pc_q;
    assign bus.branch_target_address_o = branch_target_q;
    assign bus.mispredict_o            = mispredict_q;
    assign bus.redirect_pc_o           = redirect_pc_q;
    assign occupancy_o                 = occ_q;

`ifdef BPU_PERF_COUNTER_EN
    // Counters step on the same edge that registers the pulse, so each count
    // is visible together with the pulse it counts.
    logic [31:0] perf_res_q;
    logic [31:0] perf_mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_res_q <= '0;
            perf_mis_q <= '0;
        end else begin
            if (resolve_acc && (perf_res_q != 32'hFFFF_FFFF)) begin
                perf_res_q <= perf_res_q + 32'd1;
            end
            if (resolve_mis && (perf_mis_q != 32'hFFFF_FFFF)) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign perf_resolved_o   = perf_res_q;
    assign perf_mispredict_o = perf_mis_q;
`else
    assign perf_resolved_o   = 32'h0;
    assign perf_mispredict_o = 32'h0;
`endif

endmodule

// File: tb/tb_bpu_update_queue.sv
// ---------------------------------------------------------------------------
// tb_bpu_update_queue
//   Directed scenarios followed by randomized traffic. Expected values come
//   from a queue-based reference model (exp_q holds {taken, target, pc} per
//   in-flight prediction).
//   Inputs change 1 time unit after posedge and outputs are checked 1 time
//   unit after the next posedge.
// ---------------------------------------------------------------------------
module tb_bpu_update_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
`ifdef BPU_PERF_COUNTER_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    logic flush_i;
    always #5 clk = ~clk;

    bpu_update_queue_if #(.ADDR_WIDTH(AW)) bus ();
    logic [3:0]  occupancy_o;
    logic [31:0] perf_resolved_o;
    logic [31:0] perf_mispredict_o;

    bpu_update_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .bus               (bus),
        .occupancy_o       (occupancy_o),
        .perf_resolved_o   (perf_resolved_o),
        .perf_mispredict_o (perf_mispredict_o)
    );

    // scoreboard / reference model
    logic [64:0] exp_q[$];       // {taken, target, pc}
    logic        exp_bv, exp_mis, exp_taken;
    logic [31:0] exp_pc, exp_tgt, exp_redir;
    int unsigned exp_perf_res, exp_perf_mis;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_bv = 1'b0; exp_mis = 1'b0;
        exp_perf_res = 0; exp_perf_mis = 0;
    endtask

    // One clock edge of the model. It works from the spec's rules and the
    // inputs currently driven.
    task automatic model_step();
        logic [64:0] h;
        logic res, push, mis, full, rt;
        logic [31:0] rtg;
        full = (exp_q.size() == DEPTH);
        rt   = bus.resolve_taken_i;
        rtg  = bus.resolve_target_i;
        exp_bv = 1'b0; exp_mis = 1'b0;
        if (flush_i) begin
            exp_q.delete();
        end else begin
            res  = bus.resolve_valid_i && (exp_q.size() != 0);
            push = bus.pred_valid_i && !full;
            if (res) begin
                h = exp_q[0];
                mis = (h[64] != rt) || (rt && (h[63:32] != rtg));
                exp_bv = 1'b1; exp_mis = mis;
                exp_pc = h[31:0]; exp_taken = rt; exp_tgt = rtg;
                exp_redir = rt ? rtg : h[31:0] + 32'd4;
                exp_perf_res++;
                if (mis) exp_perf_mis++;
                if (mis) exp_q.delete();
                else begin
                    void'(exp_q.pop_front());
                    if (push) exp_q.push_back({bus.pred_taken_i, bus.pred_target_i, bus.pred_pc_i});
                end
            end else if (push) begin
                exp_q.push_back({bus.pred_taken_i, bus.pred_target_i, bus.pred_pc_i});
            end
        end
    endtask

    task automatic check_all();
        check("occupancy", 64'(occupancy_o), 64'(exp_q.size()));
        check("pred_ready", 64'(bus.pred_ready_o), 64'(exp_q.size() != DEPTH));
        check("branch_valid", 64'(bus.branch_valid_o), 64'(exp_bv));
        check("mispredict", 64'(bus.mispredict_o), 64'(exp_mis));
        if (exp_bv) begin
            check("branch_pc", 64'(bus.branch_pc_o), 64'(exp_pc));
            check("branch_taken", 64'(bus.branch_taken_o), 64'(exp_taken));
            check("branch_target", 64'(bus.branch_target_address_o), 64'(exp_tgt));
            check("redirect_pc", 64'(bus.redirect_pc_o), 64'(exp_redir));
        end
        check("perf_resolved", 64'(perf_resolved_o), PERF_EN ? 64'(exp_perf_res) : 64'd0);
        check("perf_mispredict", 64'(perf_mispredict_o), PERF_EN ? 64'(exp_perf_mis) : 64'd0);
    endtask

    // driver tasks
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                         input logic rv, input logic rt, input logic [31:0] rtg, input logic fl);
        bus.pred_valid_i     = pv;
        bus.pred_pc_i        = pc;
        bus.pred_taken_i     = pt;
        bus.pred_target_i    = ptg;
        bus.resolve_valid_i  = rv;
        bus.resolve_taken_i  = rt;
        bus.resolve_target_i = rtg;
        flush_i              = fl;
        step();
        bus.pred_valid_i    = 1'b0;
        bus.resolve_valid_i = 1'b0;
        flush_i             = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        drive(1'b1, pc, pt, ptg, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] rtg);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rt, rtg, 1'b0);
    endtask

    // A resolve that agrees with the model's head entry. Only the stimulus
    // reads the model here; the expected values still come from the model step.
    task automatic resolve_hit(input logic pv, input logic [31:0] pc);
        logic [64:0] h;
        h = exp_q.size() != 0 ? exp_q[0] : 65'd0;
        drive(pv, pc, 1'b1, pc + 32'h100, 1'b1, h[64], h[63:32], 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0;
        bus.pred_valid_i = 1'b0; bus.pred_pc_i = '0; bus.pred_taken_i = 1'b0;
        bus.pred_target_i = '0; bus.resolve_valid_i = 1'b0;
        bus.resolve_taken_i = 1'b0; bus.resolve_target_i = '0;
        model_reset();

        // 1: reset values
        #2;
        check("rst_occupancy", 64'(occupancy_o), 64'd0);
        check("rst_ready", 64'(bus.pred_ready_o), 64'd1);
        check("rst_branch_valid", 64'(bus.branch_valid_o), 64'd0);
        check("rst_mispredict", 64'(bus.mispredict_o), 64'd0);
        check("rst_branch_pc", 64'(bus.branch_pc_o), 64'd0);
        check("rst_redirect", 64'(bus.redirect_pc_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        // 2: single correct prediction
        push(32'h1c00_0010, 1'b1, 32'h1c00_0100);
        check("t2_occ_after_push", 64'(occupancy_o), 64'd1);
        resolve(1'b1, 32'h1c00_0100);
        check("t2_bv", 64'(bus.branch_valid_o), 64'd1);
        check("t2_pc", 64'(bus.branch_pc_o), 64'h1c00_0010);
        check("t2_mis", 64'(bus.mispredict_o), 64'd0);
        check("t2_occ", 64'(occupancy_o), 64'd0);
        idle();

        // 3: mispredict flushes younger entries
        push(32'h1c00_0020, 1'b1, 32'h1c00_0200);
        push(32'h1c00_0030, 1'b0, 32'h1c00_0300);
        push(32'h1c00_0040, 1'b1, 32'h1c00_0400);
        resolve(1'b0, 32'h0);
        check("t3_mis", 64'(bus.mispredict_o), 64'd1);
        check("t3_redirect", 64'(bus.redirect_pc_o), 64'h1c00_0024);
        check("t3_occ", 64'(occupancy_o), 64'd0);
        idle();

        // 4: fill, overflow, push+resolve when full, drain across the wrap
        for (int i = 0; i < DEPTH; i++) push(32'h1c00_1000 + 32'(i * 4), 1'b1, 32'h1c00_2000 + 32'(i));
        check("t4_ready_full", 64'(bus.pred_ready_o), 64'd0);
        push(32'h1c00_1ff0, 1'b1, 32'h1c00_2fff);
        check("t4_occ_9th", 64'(occupancy_o), 64'd8);
        resolve_hit(1'b1, 32'h1c00_1fe0);
        check("t4_ready_back", 64'(bus.pred_ready_o), 64'd1);
        push(32'h1c00_1020, 1'b0, 32'h1c00_3000);
        for (int i = 0; i < DEPTH; i++) resolve_hit(1'b0, 32'h0);
        check("t4_drained", 64'(occupancy_o), 64'd0);

        // 5: resolve on empty, flush overriding push+resolve
        resolve(1'b1, 32'h1234);
        check("t5_empty_bv", 64'(bus.branch_valid_o), 64'd0);
        push(32'h1c00_0050, 1'b1, 32'h1c00_0500);
        push(32'h1c00_0054, 1'b1, 32'h1c00_0504);
        drive(1'b1, 32'h1c00_0058, 1'b1, 32'h0, 1'b1, 1'b1, 32'h1c00_0500, 1'b1);
        check("t5_flush_bv", 64'(bus.branch_valid_o), 64'd0);
        check("t5_flush_occ", 64'(occupancy_o), 64'd0);
        idle();

        // Reset asserted mid-operation takes effect without a clock edge
        push(32'h1c00_0060, 1'b1, 32'h1c00_0600);
        push(32'h1c00_0064, 1'b1, 32'h1c00_0604);
        resolve_hit(1'b0, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_occ", 64'(occupancy_o), 64'd0);
        check("midrst_ready", 64'(bus.pred_ready_o), 64'd1);
        check("midrst_bv", 64'(bus.branch_valid_o), 64'd0);
        check("midrst_perf", 64'(perf_resolved_o), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        // 6: perf counters after four resolves, one of them wrong
        for (int i = 0; i < 4; i++) push(32'h1c00_4000 + 32'(i * 8), 1'b1, 32'h1c00_5000);
        for (int i = 0; i < 3; i++) resolve_hit(1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        check("t6_perf_res", 64'(perf_resolved_o), PERF_EN ? 64'd4 : 64'd0);
        check("t6_perf_mis", 64'(perf_mispredict_o), PERF_EN ? 64'd1 : 64'd0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, rtg;
            logic rt;
            logic [64:0] h;
            pc = {$urandom_range(0, 32'h00ff_ffff), 2'b00} | 32'h1c00_0000;
            rt = 1'($urandom_range(0, 1));
            rtg = ($urandom_range(0, 1) != 0) ? 32'h1c00_8000 : 32'h1c00_9000;
            if (exp_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                h = exp_q[0];
                rt = h[64];
                rtg = ($urandom_range(0, 7) == 0) ? h[63:32] ^ 32'h10 : h[63:32];
            end
            drive(1'($urandom_range(0, 2) != 0), pc, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 32'h1c00_8000 : 32'h1c00_9000,
                  1'($urandom_range(0, 2) == 0), rt, rtg,
                  1'($urandom_range(0, 40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
